bus_transfer_unit: RTL and testbench

Sequencer for the CPU's 19-bit internal bus. It accepts one register-to-register transfer request (source index, destination index) and drives the 16:1 bus multiplexer select lines. It then captures the multiplexed bus value and issues a one-hot, single-cycle write strobe with the captured data to the destination register. It is the landing and control end of the shared bus: the mux chooses who talks, and this block chooses who listens and when.

---
 rtl/bus_xfer_pkg.sv | 16 +
 rtl/bus_transfer_unit_if.sv | 31 +++
 rtl/dest_decoder_4to16.sv | 19 +
 rtl/bus_transfer_unit.sv | 122 ++++++++++++
 tb/tb_bus_transfer_unit.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/bus_xfer_pkg.sv
// Shared definitions for the internal-bus transfer sequencer: widths and
// the four-state transfer sequence.
package bus_xfer_pkg;

  localparam int DATA_W   = 19;
  localparam int NUM_DEST = 16;
  localparam int SEL_W    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SELECT  = 2'd1,
    CAPTURE = 2'd2,
    WRITE   = 2'd3
  } state_e;

endpackage

// File: rtl/bus_transfer_unit_if.sv
// Request handshake, mux select, bus landing and register-write signals.
// The requester/bench side uses master; the sequencer uses slave.
interface bus_transfer_unit_if;
  import bus_xfer_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [SEL_W-1:0]    req_src;
  logic [SEL_W-1:0]    req_dst;
  logic                s3;
  logic                s2;
  logic                s1;
  logic                s0;
  logic [DATA_W-1:0]   bus_in;
  logic [DATA_W-1:0]   wr_data;
  logic [NUM_DEST-1:0] wr_en;
  logic                done;
  logic                err;
  logic                busy;

  modport master (
    output req_valid, req_src, req_dst, bus_in,
    input  req_ready, s3, s2, s1, s0, wr_data, wr_en, done, err, busy
  );

  modport slave (
    input  req_valid, req_src, req_dst, bus_in,
    output req_ready, s3, s2, s1, s0, wr_data, wr_en, done, err, busy
  );

endinterface

// File: rtl/dest_decoder_4to16.sv
// Turns a destination index into a one-hot write strobe; all zeros when
// not enabled.
module dest_decoder_4to16
  import bus_xfer_pkg::*;
(
  input  logic [SEL_W-1:0]    idx_i,
  input  logic                en_i,
  output logic [NUM_DEST-1:0] onehot_o
);

  // Set only the bit named by the index, and only when enabled.
  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_transfer_unit.sv
// Sequencer for the 19-bit internal bus: accepts a src/dst request, drives
// the 16:1 mux select, captures the bus and strobes the destination register.
// Optional feature: BUS_XFER_PROTECT_EN makes destination 0 a read-only zero
// register (write suppressed, err pulsed alongside done).
module bus_transfer_unit
  import bus_xfer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  bus_transfer_unit_if.slave  bus
);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [SEL_W-1:0]    dst_q, dst_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [NUM_DEST-1:0] wr_en_q, wr_en_d;
  logic                done_q, done_d;
  logic [NUM_DEST-1:0] dec_onehot;
  logic                accept;
  logic                protect_hit;

  assign accept = bus.req_valid && (state_q == IDLE);

`ifdef BUS_XFER_PROTECT_EN
  logic err_q, err_d;
  assign protect_hit = (dst_q == '0);
`else
  assign protect_hit = 1'b0;
`endif

  // The strobe for the latched destination, suppressed for the protected register.
  dest_decoder_4to16 u_dest_decoder (
    .idx_i    (dst_q),
    .en_i     ((state_q == CAPTURE) && !protect_hit),
    .onehot_o (dec_onehot)
  );

  // State register: reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: fixed four-step walk once a request is accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SELECT;
      SELECT:  state_d = CAPTURE;
      CAPTURE: state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next-values: latch request at accept, capture bus and build strobe leaving CAPTURE.
  always_comb begin
    sel_d     = sel_q;
    dst_d     = dst_q;
    wr_data_d = wr_data_q;
    wr_en_d   = '0;
    done_d    = 1'b0;
    if (accept) begin
      sel_d = bus.req_src;
      dst_d = bus.req_dst;
    end
    if (state_q == CAPTURE) begin
      wr_data_d = bus.bus_in;
      wr_en_d   = dec_onehot;
      done_d    = 1'b1;
    end
  end

  // Registered outputs; reset clears the strobe so an aborted transfer never writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= '0;
      dst_q     <= '0;
      wr_data_q <= '0;
      wr_en_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      dst_q     <= dst_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      done_q    <= done_d;
    end
  end

`ifdef BUS_XFER_PROTECT_EN
  // Rejection flag pulses together with done for a write to the zero register.
  always_comb begin
    err_d = (state_q == CAPTURE) && protect_hit;
  end

  // Rejection flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign {bus.s3, bus.s2, bus.s1, bus.s0} = sel_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_bus_transfer_unit.sv
// Self-checking bench for bus_transfer_unit: directed scenarios plus random
// transfers checked against a transfer-level expectation model.
module tb_bus_transfer_unit;

`ifdef BUS_XFER_PROTECT_EN
  localparam bit PROTECT = 1'b1;
`else
  localparam bit PROTECT = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cycle;

  // Model of what the block should be presenting between transfers.
  logic [3:0]  model_sel;
  logic [18:0] model_data;

  bus_transfer_unit_if bus ();

  bus_transfer_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [3:0] sel;
  assign sel = {bus.s3, bus.s2, bus.s1, bus.s0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count used to measure transfer spacing.
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [18:0] junk(input logic [18:0] avoid);
    logic [18:0] v;
    v = 19'($urandom);
    if (v == avoid) v = ~avoid;
    return v;
  endfunction

  // One complete transfer. Entered at a negedge with the block idle and
  // leaves at the negedge after WRITE, so consecutive calls run back-to-back.
  task automatic xfer(input logic [3:0] src, input logic [3:0] dst,
                      input logic [18:0] data, input bit keep_valid,
                      input bit perturb, output int wcycle);
    logic [15:0] exp_en;
    bit          exp_err;
    exp_err = PROTECT && (dst == 4'h0);
    exp_en  = exp_err ? 16'h0000 : (16'h0001 << dst);

    checks++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_ready: got ready=%b busy=%b expected ready=1 busy=0", bus.req_ready, bus.busy); end
    bus.req_valid = 1'b1; bus.req_src = src; bus.req_dst = dst; bus.bus_in = junk(data);

    @(negedge clk);
    checks++; if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0 || sel !== src) begin
      errors++; $display("[TB] FAIL select_state: got busy=%b ready=%b sel=%h expected busy=1 ready=0 sel=%h", bus.busy, bus.req_ready, sel, src); end
    checks++; if (bus.wr_en !== 16'h0 || bus.done !== 1'b0 || bus.wr_data !== model_data) begin
      errors++; $display("[TB] FAIL select_quiet: got wr_en=%h done=%b wr_data=%0d expected wr_en=0 done=0 wr_data=%0d", bus.wr_en, bus.done, bus.wr_data, model_data); end
    if (!keep_valid) bus.req_valid = 1'b0;
    if (perturb) begin bus.req_src = ~src; bus.req_dst = ~dst; end
    bus.bus_in = junk(data);

    @(negedge clk);
    checks++; if (sel !== src || bus.wr_en !== 16'h0 || bus.done !== 1'b0) begin
      errors++; $display("[TB] FAIL capture_state: got sel=%h wr_en=%h done=%b expected sel=%h wr_en=0 done=0", sel, bus.wr_en, bus.done, src); end
    bus.bus_in = data;

    @(negedge clk);
    model_data = data;
    model_sel  = src;
    wcycle     = cycle;
    checks++; if (bus.wr_en !== exp_en) begin
      errors++; $display("[TB] FAIL write_strobe: got %h expected %h", bus.wr_en, exp_en); end
    checks++; if (bus.done !== 1'b1 || bus.err !== exp_err) begin
      errors++; $display("[TB] FAIL write_done: got done=%b err=%b expected done=1 err=%b", bus.done, bus.err, exp_err); end
    checks++; if (bus.wr_data !== data || sel !== src || bus.busy !== 1'b1) begin
      errors++; $display("[TB] FAIL write_data: got data=%0d sel=%h busy=%b expected data=%0d sel=%h busy=1", bus.wr_data, sel, bus.busy, data, src); end
    bus.bus_in = junk(data);

    @(negedge clk);
    checks++; if (bus.wr_en !== 16'h0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      errors++; $display("[TB] FAIL single_pulse: got wr_en=%h done=%b err=%b expected all 0", bus.wr_en, bus.done, bus.err); end
    checks++; if (bus.wr_data !== model_data || sel !== model_sel || bus.req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL idle_hold: got data=%0d sel=%h ready=%b expected data=%0d sel=%h ready=1", bus.wr_data, sel, bus.req_ready, model_data, model_sel); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_src = 4'h5; bus.req_dst = 4'h9; bus.bus_in = 19'd777;
    model_sel = 4'h0; model_data = 19'd0;
    repeat (3) begin
      @(negedge clk);
      checks++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || sel !== 4'h0 || bus.wr_data !== 19'd0) begin
        errors++; $display("[TB] FAIL reset_vals: got ready=%b busy=%b sel=%h data=%0d expected 1 0 0 0", bus.req_ready, bus.busy, sel, bus.wr_data); end
      checks++; if (bus.wr_en !== 16'h0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
        errors++; $display("[TB] FAIL reset_strobes: got wr_en=%h done=%b err=%b expected 0", bus.wr_en, bus.done, bus.err); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int wc;
    xfer(4'h7, 4'h3, 19'd607, 1'b0, 1'b0, wc);
  endtask

  task automatic test_back_to_back();
    int wc0, wc1;
    xfer(4'hA, 4'hF, 19'd5000, 1'b1, 1'b0, wc0);
    xfer(4'h1, 4'h2, 19'd150, 1'b0, 1'b0, wc1);
    checks++; if (wc1 - wc0 !== 4) begin
      errors++; $display("[TB] FAIL b2b_spacing: got %0d cycles expected 4", wc1 - wc0); end
  endtask

  task automatic test_mid_reset();
    int wc;
    bus.req_valid = 1'b1; bus.req_src = 4'hC; bus.req_dst = 4'h6; bus.bus_in = 19'd4242;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_sel = 4'h0; model_data = 19'd0;
    checks++; if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1 || sel !== 4'h0 || bus.wr_data !== 19'd0) begin
      errors++; $display("[TB] FAIL midreset_vals: got busy=%b ready=%b sel=%h data=%0d expected 0 1 0 0", bus.busy, bus.req_ready, sel, bus.wr_data); end
    @(negedge clk);
    checks++; if (bus.wr_en !== 16'h0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_nowrite: got wr_en=%h done=%b busy=%b expected 0 0 0", bus.wr_en, bus.done, bus.busy); end
    rst_n = 1'b1;
    xfer(4'h2, 4'h9, 19'd31337, 1'b0, 1'b0, wc);
  endtask

  task automatic test_busy_ignore();
    int wc;
    xfer(4'h4, 4'hB, 19'd99, 1'b0, 1'b1, wc);
  endtask

  task automatic test_protect();
    int wc;
    xfer(4'h8, 4'h0, 19'd123, 1'b0, 1'b0, wc);
    xfer(4'h5, 4'h5, 19'h7FFFF, 1'b0, 1'b0, wc);
  endtask

  task automatic test_random();
    int wc;
    for (int i = 0; i < 24; i++) begin
      xfer(4'($urandom), 4'($urandom), 19'($urandom), 1'($urandom), 1'($urandom), wc);
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("[TB] FAIL random_idle: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cycle  = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_mid_reset();
    test_busy_ignore();
    test_protect();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
